mem_arbiter: RTL

Two-into-one arbiter between the instruction-cache and data-cache memory ports and the single external memory port. It forwards one cache's request at a time (command plus write data), grants round-robin on conflict, and routes in-order read responses back to the issuing cache via an outstanding-read tag FIFO. It sits directly downstream of both cache instances.

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-into-one arbiter between the instruction and data cache memory ports and the
// external memory port; read responses are routed back through an in-order tag FIFO.
module mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,

  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,

  output logic                   err_unexpected_resp
);

  localparam int PTR_BITS = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(MAX_OUTSTANDING);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]          state_reg;
  logic                owner_reg;
  logic                last_owner_reg;
  logic                cmd_done_reg;
  logic                data_done_reg;
  logic                err_reg;
  logic                tag_mem [MAX_OUTSTANDING];
  logic [PTR_BITS-1:0] rd_ptr_reg;
  logic [PTR_BITS-1:0] wr_ptr_reg;
  logic [PTR_BITS:0]   count_reg;

  logic granted;
  logic own_valid;
  logic own_rw;
  logic own_data_valid;
  logic eff_rw;
  logic fifo_empty;
  logic fifo_full;
  logic cmd_hs;
  logic data_hs;
  logic cmd_now;
  logic data_now;
  logic push;
  logic pop;
  logic head_owner;
  logic release_now;
  logic abort;

  assign granted        = (state_reg == ST_GRANT);
  assign own_valid      = owner_reg ? dc_req_valid      : ic_req_valid;
  assign own_rw         = owner_reg ? dc_req_rw         : ic_req_rw;
  assign own_data_valid = owner_reg ? dc_req_data_valid : ic_req_data_valid;

  assign mem_req_addr      = owner_reg ? dc_req_addr      : ic_req_addr;
  assign mem_req_rw        = own_rw;
  assign mem_req_data_bits = owner_reg ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask = owner_reg ? dc_req_data_mask : ic_req_data_mask;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);

  // Reads release on their command handshake, so a completed command implies a write
  // even if the cache has already moved on and changed rw.
  assign eff_rw = own_rw | cmd_done_reg;

  assign mem_req_valid      = granted & own_valid & ~cmd_done_reg & (own_rw | ~fifo_full);
  assign mem_req_data_valid = granted & own_data_valid & eff_rw & ~data_done_reg;

  assign cmd_hs  = mem_req_valid & mem_req_ready;
  assign data_hs = mem_req_data_valid & mem_req_data_ready;

  assign ic_req_ready      = cmd_hs  & ~owner_reg;
  assign dc_req_ready      = cmd_hs  &  owner_reg;
  assign ic_req_data_ready = data_hs & ~owner_reg;
  assign dc_req_data_ready = data_hs &  owner_reg;

  assign cmd_now     = cmd_done_reg  | cmd_hs;
  assign data_now    = data_done_reg | data_hs;
  assign push        = cmd_hs & ~own_rw;
  assign release_now = push | (eff_rw & cmd_now & data_now);
  assign abort       = ~cmd_done_reg & ~own_valid;

  assign pop        = mem_resp_valid & ~fifo_empty;
  assign head_owner = tag_mem[rd_ptr_reg];

  assign ic_resp_valid = pop & ~head_owner;
  assign dc_resp_valid = pop &  head_owner;
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  assign err_unexpected_resp = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b0;
      cmd_done_reg   <= 1'b0;
      data_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ic_req_valid | dc_req_valid) begin
            state_reg     <= ST_GRANT;
            owner_reg     <= (ic_req_valid & dc_req_valid) ? ~last_owner_reg : dc_req_valid;
            cmd_done_reg  <= 1'b0;
            data_done_reg <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (release_now) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= owner_reg;
          end else begin
            if (cmd_hs)  cmd_done_reg  <= 1'b1;
            if (data_hs) data_done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Tag FIFO: pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= owner_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (mem_resp_valid & fifo_empty) begin
      err_reg <= 1'b1;
    end
  end

endmodule
